synapse_bank: RTL and testbench
===============================

Name: synapse_bank

Overview:
Synaptic weight store and current summer between the five presynaptic LIF neurons and the postsynaptic LIF neuron. Holds one weight per synapse and each cycle forms the saturated sum of the weights of the synapses that spiked, which drives the post neuron's current input. Accepts signed weight deltas from the STDP unit over a valid/ready handshake and applies them with saturation using a 2-cycle read-modify-write.

Parameters:
N_SYN, 5, number of presynaptic synapses (1..8)
W_WIDTH, 8, unsigned weight width
W_INIT, 32, reset value of every weight
W_MIN, 0, lower weight clamp
W_MAX, 255, upper weight clamp (W_MIN <= W_INIT <= W_MAX < 2^W_WIDTH)
CUR_MAX, 255, saturation value of current_out

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset (top level drives it as ~rst_n)
pre_spike  in  N_SYN  spike vector; bit i = presynaptic neuron i fired this cycle
upd_valid  in  1  weight update request valid
upd_idx  in  3  synapse index for the update
upd_delta  in  W_WIDTH  signed two's-complement weight delta
upd_ready  out  1  bank can accept an update this cycle
upd_err  out  1  one-cycle pulse: accepted update had upd_idx >= N_SYN
current_out  out  8  registered saturated weighted spike sum
spike_cnt  out  4  registered popcount of pre_spike, aligned with current_out
rd_idx  in  3  weight readback index
rd_weight  out  W_WIDTH  combinational readback of weight[rd_idx]; 0 if rd_idx >= N_SYN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all weights = W_INIT; current_out = 0; spike_cnt = 0; upd_err = 0; FSM = IDLE, so upd_ready = 1 on the first cycle after reset deasserts.
- rst asserted mid-update (FSM in APPLY) aborts the update: no write occurs, all weights return to W_INIT.
- Summation:
  - sum = Σ weight[i] over bits with pre_spike[i] = 1.
  - Accumulate at W_WIDTH+3 bits, unsigned.
  - current_out <= (sum > CUR_MAX) ? CUR_MAX : sum.
  - Latency: 1 cycle. Spikes sampled at edge t appear on current_out after edge t.
  - pre_spike = 0 gives current_out = 0 on the next cycle; current_out holds no state between spikes.
  - spike_cnt is registered on the same edge.
- Update FSM, two states:
  - IDLE: upd_ready = 1. If upd_valid, latch upd_idx and upd_delta and go to APPLY. Otherwise stay in IDLE.
  - APPLY: upd_ready = 0. Compute nw = weight[idx] + sign_extend(delta) in W_WIDTH+2-bit signed, clamp to [W_MIN, W_MAX], write weight[idx] at the end of this cycle, return to IDLE.
  - If idx >= N_SYN in APPLY: no write, upd_err = 1 for that one cycle.
- Throughput: at most one update per 2 cycles. upd_valid held high while upd_ready = 0 is not accepted. The requester must hold the request until it sees ready.
- Write and sum in the same cycle: the sum in the APPLY cycle uses the old weight. The new weight affects current_out starting with spikes sampled the cycle after APPLY.
- rd_weight reflects the write from the edge after APPLY.
- Deltas of -128 and +127 are legal. Clamping applies at both ends with no wrap-around.

Test Plan:
- Reset, then pre_spike = 5'b00001 for one cycle -> current_out = 32 one cycle later, spike_cnt = 1; next cycle with pre_spike = 0 -> current_out = 0.
- pre_spike = 5'b11111 with all weights 32 -> current_out = 160, spike_cnt = 5. Raise weight 0 to 255 via updates, then pre_spike = 5'b11111 -> current_out = 255 (saturated; raw sum 383).
- Update idx 2, delta +100 -> upd_ready low for exactly 1 cycle, rd_weight(2) = 132. Then delta +127 twice -> 255 (clamped). Then delta -128 three times -> 0 (clamped, no wrap).
- Update idx 3, delta +10 while pre_spike[3] = 1 in the APPLY cycle -> that sum uses 32. Spike on the following cycle -> current_out = 42.
- upd_valid held high continuously with alternating idx 0 and 1 -> accepted every other cycle only; final weights match the applied count. Update idx 6 -> upd_err pulses 1 cycle, all weights unchanged.
- Assert rst during APPLY of idx 1, delta +50 -> weight 1 = 32 after reset, upd_ready = 1, current_out = 0.

Source files
------------

// File: rtl/synapse_bank.sv
// -----------------------------------------------------------------------------
// synapse_bank
//
// Synaptic weight store and current summer. It sits between N_SYN presynaptic
// LIF neurons and one postsynaptic LIF neuron. There is one unsigned weight per
// synapse. On every cycle the block adds up the weights of the synapses that
// spiked, saturates the total, and registers it as the post neuron's current.
// Signed weight deltas from the STDP unit arrive over a valid/ready handshake.
// Each delta is applied with clamping in a two-cycle read-modify-write:
// IDLE accepts the delta, APPLY writes the new weight.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   pre_spike    spike vector, bit i = presynaptic neuron i fired this cycle
//   upd_valid    weight update request valid
//   upd_idx      synapse index for the update
//   upd_delta    signed two's-complement weight delta
//   upd_ready    bank can accept an update this cycle (high in IDLE)
//   upd_err      high during an APPLY cycle whose index is out of range
//   current_out  registered saturated sum of spiking weights
//   spike_cnt    registered popcount of pre_spike, aligned with current_out
//   rd_idx       weight readback index
//   rd_weight    combinational weight[rd_idx], 0 when rd_idx >= N_SYN
// -----------------------------------------------------------------------------
module synapse_bank #(
    parameter int N_SYN   = 5,
    parameter int W_WIDTH = 8,
    parameter int W_INIT  = 32,
    parameter int W_MIN   = 0,
    parameter int W_MAX   = 255,
    parameter int CUR_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SYN-1:0]   pre_spike,
    input  logic               upd_valid,
    input  logic [2:0]         upd_idx,
    input  logic [W_WIDTH-1:0] upd_delta,
    output logic               upd_ready,
    output logic               upd_err,
    output logic [7:0]         current_out,
    output logic [3:0]         spike_cnt,
    input  logic [2:0]         rd_idx,
    output logic [W_WIDTH-1:0] rd_weight
);

    // The spike sum is W_WIDTH+3 bits wide, enough for up to 8 full-scale
    // weights. The update arithmetic is W_WIDTH+2 bits signed. That width
    // holds every value from 0 + (-2^(W-1)) up to (2^W - 1) + (2^(W-1) - 1)
    // without wrapping.
    localparam int SUM_W = W_WIDTH + 3;
    localparam int NW_W  = W_WIDTH + 2;

    localparam logic [SUM_W-1:0]       CUR_MAX_S = SUM_W'(CUR_MAX);
    localparam logic [7:0]             CUR_MAX_O = 8'(CUR_MAX);
    localparam logic signed [NW_W-1:0] W_MIN_S   = NW_W'(W_MIN);
    localparam logic signed [NW_W-1:0] W_MAX_S   = NW_W'(W_MAX);
    localparam logic [W_WIDTH-1:0]     W_INIT_V  = W_WIDTH'(W_INIT);
    localparam logic [W_WIDTH-1:0]     W_MIN_V   = W_WIDTH'(W_MIN);
    localparam logic [W_WIDTH-1:0]     W_MAX_V   = W_WIDTH'(W_MAX);
    localparam logic [3:0]             N_SYN_V   = 4'(N_SYN);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_APPLY = 1'b1
    } state_e;

    state_e state_q;
    state_e state_d;

    logic               accept;
    logic               apply;
    logic               idx_in_range;
    logic [2:0]         idx_q;
    logic [W_WIDTH-1:0] delta_q;

    logic [W_WIDTH-1:0] weight_q [N_SYN];
    logic [W_WIDTH-1:0] old_w;
    logic signed [NW_W-1:0] raw_w;
    logic [W_WIDTH-1:0] new_w;

    logic [SUM_W-1:0]   spike_sum;
    logic [3:0]         spike_pop;
    logic [7:0]         current_d;

    // ------------------------------------------------------------------
    // Update FSM
    // ------------------------------------------------------------------
    assign idx_in_range = ({1'b0, idx_q} < N_SYN_V);

    // NOTE: every output of this block gets a default before the case
    // statement. Otherwise a path that does not assign a signal would
    // infer a latch.
    always_comb begin
        state_d   = state_q;
        upd_ready = 1'b0;
        upd_err   = 1'b0;
        accept    = 1'b0;
        apply     = 1'b0;
        case (state_q)
            S_IDLE: begin
                upd_ready = 1'b1;
                if (upd_valid) begin
                    accept  = 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = S_IDLE;
                if (idx_in_range) begin
                    apply = 1'b1;
                end else begin
                    upd_err = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together at the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request when it is accepted. It is consumed in APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            delta_q <= '0;
        end else if (accept) begin
            idx_q   <= upd_idx;
            delta_q <= upd_delta;
        end
    end

    // ------------------------------------------------------------------
    // Read-modify-write datapath
    // ------------------------------------------------------------------
    // Select the weight being updated. An out-of-range index reads 0,
    // but that value is never written back.
    always_comb begin
        old_w = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (idx_q == 3'(i)) begin
                old_w = weight_q[i];
            end
        end
    end

    // Zero-extend the weight, sign-extend the delta, then clamp. The sum is
    // never truncated before clamping, so the result cannot wrap.
    always_comb begin
        raw_w = $signed({2'b00, old_w}) + $signed({{2{delta_q[W_WIDTH-1]}}, delta_q});
        if (raw_w < W_MIN_S) begin
            new_w = W_MIN_V;
        end else if (raw_w > W_MAX_S) begin
            new_w = W_MAX_V;
        end else begin
            new_w = W_WIDTH'(raw_w);
        end
    end

    // NOTE: the weight store is a handful of flops, not a RAM macro. Reset
    // therefore loads every entry, and a reset during APPLY discards the
    // pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                weight_q[i] <= W_INIT_V;
            end
        end else if (apply) begin
            for (int i = 0; i < N_SYN; i++) begin
                if (idx_q == 3'(i)) begin
                    weight_q[i] <= new_w;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Spike summation
    // ------------------------------------------------------------------
    // Reads the weights before any write on this edge. A spike sampled in
    // the APPLY cycle therefore still sees the old weight.
    always_comb begin
        spike_sum = '0;
        spike_pop = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (pre_spike[i]) begin
                spike_sum = spike_sum + SUM_W'(weight_q[i]);
            end
            spike_pop = spike_pop + 4'(pre_spike[i]);
        end
        current_d = (spike_sum > CUR_MAX_S) ? CUR_MAX_O : 8'(spike_sum);
    end

    // current_out carries no state between cycles. With no spikes it
    // returns to 0 on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_out <= '0;
            spike_cnt   <= '0;
        end else begin
            current_out <= current_d;
            spike_cnt   <= spike_pop;
        end
    end

    // ------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------
    always_comb begin
        rd_weight = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_weight = weight_q[i];
            end
        end
    end

endmodule

// File: tb/tb_synapse_bank.sv
// -----------------------------------------------------------------------------
// tb_synapse_bank
//
// Self-checking bench for synapse_bank. The behavioural model keeps the
// weights as plain integers. At every rising edge it works out what the bank
// must present afterwards. An accepted update occupies the bank for exactly
// one cycle and lands at the following edge. A compare process checks every
// DUT output against the model on each falling edge. Directed scenarios add
// hand-computed literal expectations, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_synapse_bank;

    localparam int N_SYN   = 5;
    localparam int W_INIT  = 32;
    localparam int W_MIN   = 0;
    localparam int W_MAX   = 255;
    localparam int CUR_MAX = 255;

    logic             clk;
    logic             rst;
    logic [N_SYN-1:0] pre_spike;
    logic             upd_valid;
    logic [2:0]       upd_idx;
    logic [7:0]       upd_delta;
    logic             upd_ready;
    logic             upd_err;
    logic [7:0]       current_out;
    logic [3:0]       spike_cnt;
    logic [2:0]       rd_idx;
    logic [7:0]       rd_weight;

    synapse_bank #(
        .N_SYN  (N_SYN),
        .W_WIDTH(8),
        .W_INIT (W_INIT),
        .W_MIN  (W_MIN),
        .W_MAX  (W_MAX),
        .CUR_MAX(CUR_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pre_spike  (pre_spike),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_delta  (upd_delta),
        .upd_ready  (upd_ready),
        .upd_err    (upd_err),
        .current_out(current_out),
        .spike_cnt  (spike_cnt),
        .rd_idx     (rd_idx),
        .rd_weight  (rd_weight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int mw [N_SYN];
    int exp_cur;
    int exp_cnt;
    bit m_busy;      // an accepted update is waiting to land
    int m_idx;
    int m_delta;
    bit started;
    int s_acc;
    int c_acc;

    function automatic int clamp_w(input int v);
        if (v < W_MIN) return W_MIN;
        if (v > W_MAX) return W_MAX;
        return v;
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) mw[i] = W_INIT;
            exp_cur = 0;
            exp_cnt = 0;
            m_busy  = 1'b0;
        end else begin
            s_acc = 0;
            c_acc = 0;
            for (int i = 0; i < N_SYN; i++) begin
                if (pre_spike[i]) begin
                    s_acc += mw[i];
                    c_acc++;
                end
            end
            exp_cur = (s_acc > CUR_MAX) ? CUR_MAX : s_acc;
            exp_cnt = c_acc;
            if (m_busy) begin
                if (m_idx < N_SYN) mw[m_idx] = clamp_w(mw[m_idx] + m_delta);
                m_busy = 1'b0;
            end else if (upd_valid) begin
                m_busy  = 1'b1;
                m_idx   = int'(upd_idx);
                m_delta = int'($signed(upd_delta));
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison
    // ------------------------------------------------------------------
    int exp_rd;

    always @(negedge clk) begin
        if (started) begin
            exp_rd = (int'(rd_idx) < N_SYN) ? mw[int'(rd_idx)] : 0;
            check("current_out", 32'(current_out), 32'(exp_cur));
            check("spike_cnt",   32'(spike_cnt),   32'(exp_cnt));
            check("upd_ready",   32'(upd_ready),   32'(!m_busy));
            check("upd_err",     32'(upd_err),     32'(m_busy && (m_idx >= N_SYN)));
            check("rd_weight",   32'(rd_weight),   32'(exp_rd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Raise a request and hold it until an edge sees ready. Returns 2
    // time units after the accepting edge, which is inside the APPLY cycle.
    task automatic do_update(input int idx, input int d);
        bit rdy;
        bit got;
        got       = 1'b0;
        upd_valid = 1'b1;
        upd_idx   = 3'(idx);
        upd_delta = 8'(d);
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            rdy = upd_ready;
            tick();
            if (rdy) got = 1'b1;
        end
        upd_valid = 1'b0;
        check("upd_accept", 32'(got), 32'd1);
    endtask

    task automatic read_check(input string nm, input int idx, input int exp);
        rd_idx = 3'(idx);
        #1;
        check(nm, 32'(rd_weight), 32'(exp));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bit rdy;
        int r;

        rst       = 1'b1;
        pre_spike = '0;
        upd_valid = 1'b0;
        upd_idx   = '0;
        upd_delta = '0;
        rd_idx    = '0;
        repeat (3) tick();
        check("rst_ready", 32'(upd_ready), 32'd1);
        check("rst_cur",   32'(current_out), 32'd0);
        check("rst_cnt",   32'(spike_cnt), 32'd0);
        check("rst_w0",    32'(rd_weight), 32'd32);
        rst = 1'b0;

        // A single spike, then silence.
        pre_spike = 5'b00001;
        tick();
        check("one_spike_cur", 32'(current_out), 32'd32);
        check("one_spike_cnt", 32'(spike_cnt), 32'd1);
        pre_spike = '0;
        tick();
        check("no_spike_cur", 32'(current_out), 32'd0);

        // All five synapses spike.
        pre_spike = 5'b11111;
        tick();
        check("all_spike_cur", 32'(current_out), 32'd160);
        check("all_spike_cnt", 32'(spike_cnt), 32'd5);
        pre_spike = '0;

        // Raise weight 0 to its ceiling, then saturate the sum (raw 383).
        do_update(0, 127);
        do_update(0, 127);
        tick();
        read_check("w0_clamped", 0, 255);
        pre_spike = 5'b11111;
        tick();
        check("sat_cur", 32'(current_out), 32'd255);
        pre_spike = '0;

        // Step weight 2 through the upper and lower clamps.
        do_update(2, 100);
        check("apply_ready_low", 32'(upd_ready), 32'd0);
        tick();
        check("ready_back", 32'(upd_ready), 32'd1);
        read_check("w2_plus100", 2, 132);
        do_update(2, 127);
        do_update(2, 127);
        tick();
        read_check("w2_top", 2, 255);
        do_update(2, -128);
        do_update(2, -128);
        do_update(2, -128);
        tick();
        read_check("w2_bottom", 2, 0);

        // A spike in the APPLY cycle still sees the old weight.
        do_update(3, 10);
        pre_spike = 5'b01000;
        tick();
        check("apply_old_w", 32'(current_out), 32'd32);
        tick();
        check("after_apply_w", 32'(current_out), 32'd42);
        pre_spike = '0;

        // Valid held high with alternating index: only the even-phase
        // requests (idx 0) land, one every two cycles. That is 5 of 10.
        upd_valid = 1'b1;
        upd_delta = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            upd_idx = 3'(c % 2);
            tick();
        end
        upd_valid = 1'b0;
        tick();
        read_check("held_w0", 0, 250);
        read_check("held_w1", 1, 32);

        // An out-of-range index signals an error and writes nothing.
        do_update(6, 5);
        check("err_pulse", 32'(upd_err), 32'd1);
        tick();
        check("err_clear", 32'(upd_err), 32'd0);

        // Reset during APPLY aborts the write.
        do_update(1, 50);
        pre_spike = 5'b11111;
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        pre_spike = '0;
        check("abort_ready", 32'(upd_ready), 32'd1);
        check("abort_cur",   32'(current_out), 32'd0);
        read_check("abort_w1", 1, 32);

        // Randomized traffic. Each request is held until accepted.
        for (int k = 0; k < 400; k++) begin
            pre_spike = N_SYN'($urandom);
            rd_idx    = 3'($urandom);
            if (!upd_valid && $urandom_range(0, 2) == 0) begin
                upd_valid = 1'b1;
                upd_idx   = 3'($urandom_range(0, 7));
                r         = int'($urandom_range(0, 5));
                if (r == 0)      upd_delta = 8'h80;
                else if (r == 1) upd_delta = 8'h7F;
                else             upd_delta = 8'($urandom);
            end
            @(negedge clk);
            rdy = upd_ready;
            tick();
            if (upd_valid && rdy) upd_valid = 1'b0;
        end
        upd_valid = 1'b0;
        pre_spike = '0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
